// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } ccff_state_e;

  // Bits of the next word that still fit in the chain; the rest are dropped.
  function automatic int unsigned ccff_part_len(input int unsigned word_w,
                                                input int unsigned remaining);
    return (remaining < word_w) ? remaining : word_w;
  endfunction

endpackage

// File: rtl/ccff_word_piso.sv
// One-word parallel-in/serial-out buffer: shifts LSB-first while cnt_o is non-zero.
module ccff_word_piso
  import ccff_loader_pkg::*;
#(
  parameter  int WORD_W = 8,
  localparam int BC_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [BC_W-1:0]   cnt_i,
  output logic              bit_o,
  output logic [BC_W-1:0]   cnt_o
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (load_i) begin
      shreg_d = data_i;
      cnt_d   = cnt_i;
    end else if (cnt_q != '0) begin
      shreg_d = shreg_q >> 1;
      cnt_d   = cnt_q - BC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_o = shreg_q[0];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams bitstream words LSB-first into the ccff chain, then checks the tail
// against the first bit shifted in. bs_data moves on a cycle with bs_valid && bs_ready.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter  int CHAIN_LEN = 1024,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1),
  localparam int BC_W      = $clog2(WORD_W + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              chain_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output ccff_state_e       dbg_state_o
);

  ccff_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             first_bit_q, first_bit_d;
  logic             cfg_err_q, cfg_err_d;
  logic             chain_en_q, chain_en_d;
  logic             head_q, head_d;
  logic             piso_clr, piso_load, piso_bit, accept;
  logic [BC_W-1:0]  piso_cnt, load_cnt;

  assign bs_ready = !pReset && !abort && (state_q == ST_LOAD) && (piso_cnt == '0)
                    && (acc_cnt_q < CNT_W'(CHAIN_LEN));
  assign accept   = bs_ready && bs_valid;
  assign load_cnt = BC_W'(ccff_part_len(WORD_W, CHAIN_LEN - int'(acc_cnt_q)));

  ccff_word_piso #(.WORD_W(WORD_W)) u_piso (
    .clk_i  (prog_clk),
    .rst_i  (pReset),
    .clr_i  (piso_clr),
    .load_i (piso_load),
    .data_i (bs_data),
    .cnt_i  (load_cnt),
    .bit_o  (piso_bit),
    .cnt_o  (piso_cnt)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    first_bit_d = first_bit_q;
    cfg_err_d   = cfg_err_q;
    chain_en_d  = 1'b0;
    head_d      = head_q;
    piso_clr    = 1'b0;
    piso_load   = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      piso_clr  = 1'b1;
      cfg_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_LOAD;
            bit_cnt_d = '0;
            acc_cnt_d = '0;
            cfg_err_d = 1'b0;
            piso_clr  = 1'b1;
          end
        end
        ST_LOAD: begin
          if (piso_cnt != '0) begin
            chain_en_d = 1'b1;
            head_d     = piso_bit;
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
          if (accept) begin
            piso_load = 1'b1;
            acc_cnt_d = acc_cnt_q + CNT_W'(load_cnt);
            if (acc_cnt_q == '0) first_bit_d = bs_data[0];
          end
          // Last bit is on the head now; the chain captures it at this edge.
          if (bit_cnt_q == CNT_W'(CHAIN_LEN)) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          cfg_err_d = (ccff_tail != first_bit_q);
          state_d   = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      acc_cnt_q   <= '0;
      first_bit_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      chain_en_q  <= 1'b0;
      head_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      first_bit_q <= first_bit_d;
      cfg_err_q   <= cfg_err_d;
      chain_en_q  <= chain_en_d;
      head_q      <= head_d;
    end
  end

  assign ccff_head   = head_q;
  assign chain_en    = chain_en_q;
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign cfg_done    = (state_q == ST_DONE);
  assign cfg_err     = cfg_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader with a behavioural configuration chain.
module tb_ccff_bitstream_loader;
  import ccff_loader_pkg::*;

  localparam int CHAIN_LEN = 20;
  localparam int WORD_W    = 8;

  logic              prog_clk = 1'b0;
  logic              pReset   = 1'b1;
  logic              start    = 1'b0;
  logic              abort    = 1'b0;
  logic [WORD_W-1:0] bs_data  = '0;
  logic              bs_valid = 1'b0;
  logic              bs_ready, ccff_head, chain_en, ccff_tail;
  logic              busy, cfg_done, cfg_err;
  ccff_state_e       dbg_state;

  ccff_bitstream_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .start       (start),
    .abort       (abort),
    .bs_data     (bs_data),
    .bs_valid    (bs_valid),
    .bs_ready    (bs_ready),
    .ccff_head   (ccff_head),
    .chain_en    (chain_en),
    .ccff_tail   (ccff_tail),
    .busy        (busy),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .dbg_state_o (dbg_state)
  );

  // Clock / behavioural chain (position 0 at the head)
  always #5 prog_clk = ~prog_clk;

  logic [CHAIN_LEN-1:0] chain = '0;
  int                   model_len = CHAIN_LEN;
  always @(posedge prog_clk) if (chain_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  assign ccff_tail = (model_len == CHAIN_LEN - 1) ? chain[CHAIN_LEN-2] : chain[CHAIN_LEN-1];

  // Scoreboard state
  int               checks = 0, fails = 0;
  logic [7:0]       word_q[$];
  logic [0:0]       exp_q[$];
  logic [0:0]       stream_bits[$];
  int               cyc = 0, en_cnt = 0, first_en = 0, last_en = 0;
  int               accepted = 0, done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: every enabled cycle must carry the next expected stream bit.
  always @(negedge prog_clk) begin
    cyc++;
    if (chain_en) begin
      if (en_cnt == 0) first_en = cyc;
      last_en = cyc;
      en_cnt++;
      if (exp_q.size() == 0) check("extra_enable", 1, 0);
      else check("head_bit", 32'(ccff_head), 32'(exp_q.pop_front()));
    end
  end

  // Reference: the first CHAIN_LEN stream bits, LSB of each word first.
  task automatic build_expect();
    stream_bits.delete();
    foreach (word_q[i])
      for (int b = 0; b < WORD_W; b++)
        if (stream_bits.size() < CHAIN_LEN) stream_bits.push_back(word_q[i][b]);
    exp_q = stream_bits;
  endtask

  function automatic logic [CHAIN_LEN-1:0] exp_image();
    logic [CHAIN_LEN-1:0] img;
    for (int p = 0; p < CHAIN_LEN; p++) img[p] = stream_bits[CHAIN_LEN-1-p];
    return img;
  endfunction

  function automatic logic exp_err();
    // Tail of an L-flop chain holds stream bit CHAIN_LEN-L after CHAIN_LEN shifts.
    return stream_bits[CHAIN_LEN - model_len] != stream_bits[0];
  endfunction

  task automatic fill_words(input bit fixed);
    word_q.delete();
    if (fixed) begin
      word_q.push_back(8'hA5); word_q.push_back(8'h3C); word_q.push_back(8'h0F);
    end else begin
      for (int i = 0; i < 3; i++) word_q.push_back(8'($urandom));
    end
    build_expect();
  endtask

  // Driver: start a load and feed word_q; stop early after stop_at enables if non-zero.
  task automatic run_load(input bit rand_valid, input int stop_at);
    en_cnt = 0; accepted = 0; done_cyc = 0;
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (stop_at != 0 && en_cnt >= stop_at) break;
      if (word_q.size() > 0 && (!rand_valid || $urandom_range(0, 2) != 0)) begin
        bs_valid = 1'b1; bs_data = word_q[0];
      end else begin
        bs_valid = 1'b0; bs_data = 8'($urandom);
      end
      @(negedge prog_clk); #1;
      if (t == 0) begin
        check("busy_after_start", 32'(busy), 1);
        check("done_low_after_start", 32'(cfg_done), 0);
      end
      if (bs_valid && bs_ready) begin
        void'(word_q.pop_front());
        accepted++;
      end
      if (cfg_done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge prog_clk); #1;
    end
    bs_valid = 1'b0;
    if (stop_at == 0) check("load_completes", 32'(cfg_done), 1);
  endtask

  task automatic check_full(input string tag, input bit check_span);
    check({tag, "_enables"}, 32'(en_cnt), CHAIN_LEN);
    check({tag, "_words"}, 32'(accepted), 3);
    check({tag, "_leftover"}, 32'(exp_q.size()), 0);
    check({tag, "_done_lat"}, 32'(done_cyc - last_en), 2);
    check({tag, "_err"}, 32'(cfg_err), 32'(exp_err()));
    if (model_len == CHAIN_LEN) check({tag, "_image"}, 32'(chain), 32'(exp_image()));
    if (check_span) check({tag, "_span"}, 32'(last_en - first_en), CHAIN_LEN + 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(bs_ready), 0);
    check({tag, "_head"}, 32'(ccff_head), 0);
    check({tag, "_chain_en"}, 32'(chain_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(cfg_done), 0);
    check({tag, "_err"}, 32'(cfg_err), 0);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge prog_clk);
    #1 pReset = 1'b0;
    @(negedge prog_clk); #1;
    check_outputs_zero("reset");
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // Full load, valid held high
    model_len = CHAIN_LEN;
    fill_words(1'b1);
    run_load(1'b0, 0);
    check_full("full", 1'b1);

    // Backpressure with random valid
    for (int r = 0; r < 3; r++) begin
      fill_words(1'b0);
      run_load(1'b1, 0);
      check_full("bp", 1'b0);
    end

    // Length fault: 19-flop chain
    model_len = CHAIN_LEN - 1;
    fill_words(1'b1);
    run_load(1'b0, 0);
    check_full("lenfault", 1'b0);
    check("lenfault_err_set", 32'(cfg_err), 1);
    model_len = CHAIN_LEN;

    // Abort after 10 enabled bits, with a word offered in the abort cycle
    fill_words(1'b0);
    run_load(1'b0, 10);
    abort = 1'b1; bs_valid = 1'b1; bs_data = 8'h5A; start = 1'b1;
    @(negedge prog_clk); #1;
    check("abort_blocks_ready", 32'(bs_ready), 0);
    @(posedge prog_clk); #1 abort = 1'b0; bs_valid = 1'b0; start = 1'b0;
    @(negedge prog_clk); #1;
    check("abort_chain_en", 32'(chain_en), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(cfg_done), 0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();

    // Clean full load after abort
    fill_words(1'b0);
    run_load(1'b0, 0);
    check_full("post_abort", 1'b1);

    // Reprogram from DONE with a new stream
    fill_words(1'b0);
    run_load(1'b1, 0);
    check_full("reprog", 1'b0);

    // Reset at bit 5, start held during reset
    fill_words(1'b0);
    run_load(1'b0, 5);
    pReset = 1'b1; start = 1'b1;
    @(posedge prog_clk); #1;
    @(negedge prog_clk); #1;
    check_outputs_zero("midreset");
    @(posedge prog_clk); #1 pReset = 1'b0; start = 1'b0;
    @(negedge prog_clk); #1;
    check("midreset_start_ignored", 32'(busy), 0);
    check("midreset_no_enable", 32'(chain_en), 0);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
